// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO: N requesters share one write port.
// Define FIFO_WR_ARB_BURST_EN to enable locked bursts of up to MAX_BURST beats.
module fifo_wr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ-1:0]              lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    input  logic                            full,
    output logic [NUM_REQ-1:0]              gnt,
    output logic [$clog2(NUM_REQ)-1:0]      gnt_id,
    output logic                            w_en,
    output logic [DATA_WIDTH-1:0]           data_in
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic [ID_W-1:0] ptr, ptr_nxt;
    logic            rr_hit;
    logic [ID_W-1:0] rr_idx;
    logic            grant_raw;
    logic [ID_W-1:0] grant_idx;
    logic            grant;

    function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + 1'b1;
    endfunction

    // First requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        logic [ID_W:0] sum;
        rr_hit = 1'b0;
        rr_idx = '0;
        sum    = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, ptr} + (ID_W+1)'(k);
            if (sum >= (ID_W+1)'(NUM_REQ))
                sum = sum - (ID_W+1)'(NUM_REQ);
            if (!rr_hit && req[sum[ID_W-1:0]]) begin
                rr_hit = 1'b1;
                rr_idx = sum[ID_W-1:0];
            end
        end
    end

`ifdef FIFO_WR_ARB_BURST_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, BURST} state_t;

    state_t           state, state_nxt;
    logic [ID_W-1:0]  owner, owner_nxt;
    logic [CNT_W-1:0] beat_cnt, beat_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            owner    <= owner_nxt;
            beat_cnt <= beat_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        owner_nxt = owner;
        beat_nxt  = beat_cnt;
        grant_raw = 1'b0;
        grant_idx = '0;
        case (state)
            ARB: begin
                if (!full && rr_hit) begin
                    grant_raw = 1'b1;
                    grant_idx = rr_idx;
                    ptr_nxt   = wrap_inc(rr_idx);
                    // The arbitration grant is beat 1 of the burst.
                    if (lock[rr_idx]) begin
                        state_nxt = BURST;
                        owner_nxt = rr_idx;
                        beat_nxt  = CNT_W'(1);
                    end
                end
            end
            BURST: begin
                if (!(req[owner] && lock[owner])) begin
                    state_nxt = ARB;
                    ptr_nxt   = wrap_inc(owner);
                    beat_nxt  = '0;
                end else if (!full) begin
                    grant_raw = 1'b1;
                    grant_idx = owner;
                    beat_nxt  = beat_cnt + CNT_W'(1);
                    if (beat_cnt == CNT_W'(MAX_BURST - 1)) begin
                        state_nxt = ARB;
                        ptr_nxt   = wrap_inc(owner);
                        beat_nxt  = '0;
                    end
                end
            end
            default: state_nxt = ARB;
        endcase
    end
`else
    logic unused_lock;
    assign unused_lock = ^lock;

    always_ff @(posedge clk) begin
        if (rst)
            ptr <= '0;
        else
            ptr <= ptr_nxt;
    end

    always_comb begin
        grant_raw = !full && rr_hit;
        grant_idx = rr_idx;
        ptr_nxt   = ptr;
        if (grant_raw)
            ptr_nxt = wrap_inc(rr_idx);
    end
`endif

    assign grant = grant_raw && !rst;

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        w_en    = 1'b0;
        data_in = '0;
        if (grant) begin
            gnt[grant_idx] = 1'b1;
            gnt_id         = grant_idx;
            w_en           = 1'b1;
            data_in        = req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// against a reference model; follows FIFO_WR_ARB_BURST_EN like the design does.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    lock;
    logic [N*DW-1:0] req_data;
    logic            full;
    logic [N-1:0]    gnt;
    logic [1:0]      gnt_id;
    logic            w_en;
    logic [DW-1:0]   data_in;

    logic [DW-1:0]   word [N];

    always #5 clk = ~clk;

    always_comb begin
        req_data = '0;
        for (int i = 0; i < N; i++)
            req_data[i*DW +: DW] = word[i];
    end

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (N),
        .MAX_BURST  (MB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .req_data (req_data),
        .full     (full),
        .gnt      (gnt),
        .gnt_id   (gnt_id),
        .w_en     (w_en),
        .data_in  (data_in)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: rotating priority pointer plus remaining beats of a locked burst.
    int m_ptr   = 0;
    bit m_burst = 1'b0;
    int m_owner = 0;
    int m_left  = 0;

    int last_g;
    int last_obs;
    bit last_wen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int model_pick();
        if (rst || full)
            return -1;
        if (m_burst)
            return (req[m_owner[1:0]] && lock[m_owner[1:0]]) ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (req[idx[1:0]])
                return idx;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        if (rst) begin
            m_ptr = 0; m_burst = 1'b0; m_owner = 0; m_left = 0;
        end else if (m_burst) begin
            if (!(req[m_owner[1:0]] && lock[m_owner[1:0]])) begin
                m_burst = 1'b0;
                m_ptr   = (m_owner + 1) % N;
            end else if (g >= 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_burst = 1'b0;
                    m_ptr   = (m_owner + 1) % N;
                end
            end
        end else if (g >= 0) begin
            m_ptr = (g + 1) % N;
            if (BE && lock[g[1:0]]) begin
                m_burst = 1'b1;
                m_owner = g;
                m_left  = MB - 1;
            end
        end
    endtask

    // One clock: drive inputs after the falling edge, check outputs, then advance the model.
    task automatic step(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                        input logic f);
        int g;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_data;
        @(negedge clk);
        rst = r; req = rq; lock = lk; full = f;
        #1;
        g      = model_pick();
        e_gnt  = (g >= 0) ? N'(1 << g) : '0;
        e_data = (g >= 0) ? word[g] : '0;
        chk("gnt",     32'(gnt),     32'(e_gnt));
        chk("gnt_id",  32'(gnt_id),  (g >= 0) ? 32'(g) : 32'd0);
        chk("w_en",    32'(w_en),    (g >= 0) ? 32'd1 : 32'd0);
        chk("data_in", 32'(data_in), 32'(e_data));
        last_g   = g;
        last_wen = w_en;
        last_obs = w_en ? int'(gnt_id) : -1;
        @(posedge clk);
        model_update(g);
        if (g >= 0)
            word[g] = DW'($urandom);
    endtask

    task automatic chk_id(input string tag, input int e);
        chk(tag, 32'(last_obs), 32'(e));
    endtask

    initial begin
        int fcount;
        logic [N-1:0] pend;
        logic [N-1:0] lk;
        logic r;
        for (int i = 0; i < N; i++)
            word[i] = DW'($urandom);
        rst = 1'b1; req = '0; lock = '0; full = 1'b0;

        // Reset with all requesting, then first grant goes to requester 0.
        step(1, 4'b1111, 4'b0000, 0); chk_id("rst_c1", -1);
        step(1, 4'b1111, 4'b0000, 0); chk_id("rst_c2", -1);
        for (int i = 0; i < 8; i++) begin
            step(0, 4'b1111, 4'b0000, 0);
            chk_id("rr_seq", i % N);
        end

        // Full back-pressure, then 1 then 2 once full drops.
        for (int i = 0; i < 3; i++) begin
            step(0, 4'b0110, 4'b0000, 1);
            chk_id("full_block", -1);
        end
        step(0, 4'b0110, 4'b0000, 0); chk_id("full_rel1", 1);
        step(0, 4'b0110, 4'b0000, 0); chk_id("full_rel2", 2);

        // Locked burst by 2 with requester 0 waiting.
        step(0, 4'b0010, 4'b0000, 0); chk_id("burst_pre", 1);
        step(0, 4'b0101, 4'b0100, 0); chk_id("burst_b1", 2);
        step(0, 4'b0101, 4'b0100, 0); chk_id("burst_b2", BE ? 2 : 0);
        step(0, 4'b0101, 4'b0100, 0); chk_id("burst_b3", 2);
        step(0, 4'b0101, 4'b0100, 0); chk_id("burst_b4", BE ? 2 : 0);
        step(0, 4'b0101, 4'b0100, 0); chk_id("burst_end", BE ? 0 : 2);

        // Same burst, stalled by full after beat 2.
        step(0, 4'b0010, 4'b0000, 0); chk_id("stall_pre", 1);
        step(0, 4'b0101, 4'b0100, 0); chk_id("stall_b1", 2);
        step(0, 4'b0101, 4'b0100, 0); chk_id("stall_b2", BE ? 2 : 0);
        step(0, 4'b0101, 4'b0100, 1); chk_id("stall_f1", -1);
        step(0, 4'b0101, 4'b0100, 1); chk_id("stall_f2", -1);
        step(0, 4'b0101, 4'b0100, 0); chk_id("stall_b3", 2);
        step(0, 4'b0101, 4'b0100, 0); chk_id("stall_b4", BE ? 2 : 0);
        step(0, 4'b0101, 4'b0100, 0); chk_id("stall_end", BE ? 0 : 2);

        // Lock drops after two beats: idle cycle, then pointer sits at 2.
        step(0, 4'b0010, 4'b0010, 0); chk_id("abort_b1", 1);
        step(0, 4'b0010, 4'b0010, 0); chk_id("abort_b2", 1);
        step(0, 4'b0010, 4'b0000, 0); chk_id("abort_idle", BE ? -1 : 1);
        step(0, 4'b1111, 4'b0000, 0); chk_id("abort_ptr", 2);

        // Reset in the middle of a burst restarts arbitration from 0.
        step(0, 4'b0001, 4'b0001, 0); chk_id("rstb_b1", 0);
        step(0, 4'b0001, 4'b0001, 0); chk_id("rstb_b2", 0);
        step(1, 4'b1111, 4'b0000, 0); chk_id("rstb_rst", -1);
        step(0, 4'b1111, 4'b0000, 0); chk_id("rstb_ptr0", 0);
        step(0, 4'b1111, 4'b0000, 0); chk_id("rstb_arb", 1);

        // Random traffic into a depth-8 FIFO drained at random.
        fcount = 0;
        pend   = '0;
        for (int c = 0; c < 400; c++) begin
            pend = pend | (N'($urandom) & N'($urandom));
            lk   = '0;
            for (int i = 0; i < N; i++)
                lk[i] = pend[i] && ($urandom_range(3) != 0);
            r = ($urandom_range(49) == 0);
            step(r, pend, lk, fcount == 8);
            if (last_g >= 0)
                pend[last_g] = 1'b0;
            if (last_wen)
                fcount++;
            if (fcount > 0 && $urandom_range(2) == 0)
                fcount--;
            chk("fifo_level_ok", 32'(fcount <= 8), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
